// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Datapath control word produced for every state
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       illegal_op;
   } ctrl_word_t;

   // True for the opcodes this controller knows how to sequence
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle.
interface mips_multicycle_ctrl_if;
   import mips_pkg::*;

   logic [OP_W-1:0]    opcode;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               pc_en;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               mem_to_reg;
   logic [1:0]         pc_source;
   logic [1:0]         alu_op;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic               reg_write;
   logic               reg_dst;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
             reg_write, reg_dst, illegal_op, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
             reg_write, reg_dst, illegal_op, state
   );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control-word decode (Moore outputs plus pc_en).
module mips_ctrl_decode
   import mips_pkg::*;
(
   input  state_t          i_state,
   input  logic            i_rst,
   input  logic            i_zero,
   input  logic            i_mem_ready,
   input  logic [OP_W-1:0] i_opcode,
   output ctrl_word_t      o_ctrl,
   output logic            o_pc_en
);

   ctrl_word_t w_word;

   // Per-state control word; strobes are squashed while in reset
   always_comb begin
      w_word = '0;
      case (i_state)
         S_FETCH: begin
            w_word.mem_read  = 1'b1;
            w_word.alu_src_b = SRCB_FOUR;
            w_word.ir_write  = i_mem_ready;
            w_word.pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            w_word.alu_src_b  = SRCB_IMM_SH;
            w_word.illegal_op = ~is_legal_op(i_opcode);
         end
         S_MEMADR, S_ADDIEX: begin
            w_word.alu_src_a = 1'b1;
            w_word.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            w_word.mem_read = 1'b1;
            w_word.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            w_word.reg_write  = 1'b1;
            w_word.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            w_word.mem_write = 1'b1;
            w_word.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            w_word.alu_src_a = 1'b1;
            w_word.alu_src_b = SRCB_B;
            w_word.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            w_word.reg_write = 1'b1;
            w_word.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            w_word.alu_src_a     = 1'b1;
            w_word.alu_op        = ALU_SUB;
            w_word.pc_write_cond = 1'b1;
            w_word.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            w_word.pc_write  = 1'b1;
            w_word.pc_source = PCSRC_JUMP;
         end
         S_ADDIWB: begin
            w_word.reg_write = 1'b1;
         end
         default: ;
      endcase
      if (i_rst) begin
         w_word.pc_write      = 1'b0;
         w_word.pc_write_cond = 1'b0;
         w_word.ir_write      = 1'b0;
         w_word.mem_read      = 1'b0;
         w_word.mem_write     = 1'b0;
         w_word.reg_write     = 1'b0;
         w_word.illegal_op    = 1'b0;
      end
   end

   assign o_ctrl  = w_word;
   assign o_pc_en = w_word.pc_write | (w_word.pc_write_cond & i_zero);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, sequencing and output fan-out.
module mips_multicycle_ctrl
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   mips_multicycle_ctrl_if.master bus
);

   state_t     r_state;
   ctrl_word_t w_ctrl;
   logic       w_pc_en;

   // State sequencing; memory states hold until mem_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:  r_state <= bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_R:         r_state <= S_EXEC;
                  OP_BEQ:       r_state <= S_BRANCH;
                  OP_J:         r_state <= S_JUMP;
                  OP_ADDI:      r_state <= S_ADDIEX;
                  default:      r_state <= S_FETCH;
               endcase
            end
            S_MEMADR: begin
               if (bus.opcode == OP_LW)      r_state <= S_MEMRD;
               else if (bus.opcode == OP_SW) r_state <= S_MEMWR;
               else                          r_state <= S_FETCH;
            end
            S_MEMRD:  r_state <= bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  r_state <= S_FETCH;
            S_MEMWR:  r_state <= bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   r_state <= S_RWB;
            S_RWB:    r_state <= S_FETCH;
            S_BRANCH: r_state <= S_FETCH;
            S_JUMP:   r_state <= S_FETCH;
            S_ADDIEX: r_state <= S_ADDIWB;
            S_ADDIWB: r_state <= S_FETCH;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   mips_ctrl_decode u_decode (
      .i_state     (r_state),
      .i_rst       (rst),
      .i_zero      (bus.zero),
      .i_mem_ready (bus.mem_ready),
      .i_opcode    (bus.opcode),
      .o_ctrl      (w_ctrl),
      .o_pc_en     (w_pc_en)
   );

   assign bus.pc_write      = w_ctrl.pc_write;
   assign bus.pc_write_cond = w_ctrl.pc_write_cond;
   assign bus.pc_en         = w_pc_en;
   assign bus.i_or_d        = w_ctrl.i_or_d;
   assign bus.mem_read      = w_ctrl.mem_read;
   assign bus.mem_write     = w_ctrl.mem_write;
   assign bus.ir_write      = w_ctrl.ir_write;
   assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
   assign bus.pc_source     = w_ctrl.pc_source;
   assign bus.alu_op        = w_ctrl.alu_op;
   assign bus.alu_src_a     = w_ctrl.alu_src_a;
   assign bus.alu_src_b     = w_ctrl.alu_src_b;
   assign bus.reg_write     = w_ctrl.reg_write;
   assign bus.reg_dst       = w_ctrl.reg_dst;
   assign bus.illegal_op    = w_ctrl.illegal_op;
   assign bus.state         = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table through a scoreboard queue,
// plus latency sequences.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, JMP = 6'h02,
                          ADDI = 6'h08, RT = 6'h00, ILL = 6'h3F;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_en;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       illegal_op;
   } out_t;

   // keys = {pc_en, mem_read, mem_write, reg_write, illegal_op}
   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       zero;
      logic       mr;
      int         st;
      logic [4:0] keys;
   } row_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   row_t tbl[$];
   row_t sb[$];

   mips_multicycle_ctrl_if u_if ();

   mips_multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input int st, input logic [4:0] keys);
      row_t t;
      t.rst = r; t.op = op; t.zero = z; t.mr = mr; t.st = st; t.keys = keys;
      tbl.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected outputs for a state, written from the controller's state table
   function automatic out_t model(input int st, input logic r, input logic mr,
                                  input logic z, input logic [5:0] op);
      out_t o = '0;
      case (st)
         0:  begin o.mem_read = 1; o.alu_src_b = 2'd1; o.ir_write = mr; o.pc_write = mr; end
         1:  begin
                o.alu_src_b  = 2'd3;
                o.illegal_op = !(op == RT || op == LW || op == SW || op == BEQ ||
                                 op == JMP || op == ADDI);
             end
         2:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
         3:  begin o.mem_read = 1; o.i_or_d = 1; end
         4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
         5:  begin o.mem_write = 1; o.i_or_d = 1; end
         6:  begin o.alu_src_a = 1; o.alu_op = 2'd2; end
         7:  begin o.reg_write = 1; o.reg_dst = 1; end
         8:  begin o.alu_src_a = 1; o.alu_op = 2'd1; o.pc_write_cond = 1; o.pc_source = 2'd1; end
         9:  begin o.pc_write = 1; o.pc_source = 2'd2; end
         10: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
         11: begin o.reg_write = 1; end
         default: ;
      endcase
      if (r) begin
         o.pc_write = 0; o.pc_write_cond = 0; o.ir_write = 0; o.mem_read = 0;
         o.mem_write = 0; o.reg_write = 0; o.illegal_op = 0;
      end
      o.pc_en = o.pc_write | (o.pc_write_cond & z);
      return o;
   endfunction

   function automatic out_t sample();
      out_t a;
      a.pc_write = u_if.pc_write;     a.pc_write_cond = u_if.pc_write_cond;
      a.pc_en = u_if.pc_en;           a.i_or_d = u_if.i_or_d;
      a.mem_read = u_if.mem_read;     a.mem_write = u_if.mem_write;
      a.ir_write = u_if.ir_write;     a.mem_to_reg = u_if.mem_to_reg;
      a.pc_source = u_if.pc_source;   a.alu_op = u_if.alu_op;
      a.alu_src_a = u_if.alu_src_a;   a.alu_src_b = u_if.alu_src_b;
      a.reg_write = u_if.reg_write;   a.reg_dst = u_if.reg_dst;
      a.illegal_op = u_if.illegal_op;
      return a;
   endfunction

   task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
      rst = r; u_if.opcode = op; u_if.zero = z; u_if.mem_ready = mr;
   endtask

   // Count clock edges from a FETCH until the controller returns to FETCH
   task automatic measure(input string name, input logic [5:0] op, input int exp_cycles);
      int cnt;
      @(negedge clk); drive(1'b1, op, 1'b0, 1'b1);
      @(negedge clk); drive(1'b0, op, 1'b0, 1'b1);
      #1 check({name, "_start"}, 32'(u_if.state), 32'd0);
      cnt = 0;
      do begin
         @(posedge clk); #1; cnt++;
      end while (u_if.state != 4'd0 && cnt < 20);
      check({name, "_latency"}, 32'(cnt), 32'(exp_cycles));
   endtask

   initial begin
      out_t act, exp, msk;
      row_t cur;
      // reset, then LW with ready memory
      add(1, LW, 0, 1, 0, 5'b00000);
      add(0, LW, 0, 1, 0, 5'b11000); add(0, LW, 0, 1, 1, 5'b00000);
      add(0, LW, 0, 1, 2, 5'b00000); add(0, LW, 0, 1, 3, 5'b01000);
      add(0, LW, 0, 1, 4, 5'b00010);
      // SW with two wait cycles in MEMWR
      add(0, SW, 0, 1, 0, 5'b11000); add(0, SW, 0, 1, 1, 5'b00000);
      add(0, SW, 0, 1, 2, 5'b00000); add(0, SW, 0, 0, 5, 5'b00100);
      add(0, SW, 0, 0, 5, 5'b00100); add(0, SW, 0, 1, 5, 5'b00100);
      // R-type with one FETCH wait
      add(0, RT, 0, 0, 0, 5'b01000); add(0, RT, 0, 1, 0, 5'b11000);
      add(0, RT, 0, 1, 1, 5'b00000); add(0, RT, 0, 1, 6, 5'b00000);
      add(0, RT, 0, 1, 7, 5'b00010);
      // BEQ taken, then not taken
      add(0, BEQ, 1, 1, 0, 5'b11000); add(0, BEQ, 1, 1, 1, 5'b00000);
      add(0, BEQ, 1, 1, 8, 5'b10000);
      add(0, BEQ, 0, 1, 0, 5'b11000); add(0, BEQ, 0, 1, 1, 5'b00000);
      add(0, BEQ, 0, 1, 8, 5'b00000);
      // J and ADDI
      add(0, JMP, 0, 1, 0, 5'b11000); add(0, JMP, 0, 1, 1, 5'b00000);
      add(0, JMP, 0, 1, 9, 5'b10000);
      add(0, ADDI, 0, 1, 0, 5'b11000); add(0, ADDI, 0, 1, 1, 5'b00000);
      add(0, ADDI, 0, 1, 10, 5'b00000); add(0, ADDI, 0, 1, 11, 5'b00010);
      // illegal opcode skipped back to FETCH
      add(0, ILL, 0, 1, 0, 5'b11000); add(0, ILL, 0, 1, 1, 5'b00001);
      // LW stalled in MEMRD, reset held 3 cycles, then FETCH
      add(0, LW, 0, 1, 0, 5'b11000); add(0, LW, 0, 1, 1, 5'b00000);
      add(0, LW, 0, 1, 2, 5'b00000); add(0, LW, 0, 0, 3, 5'b01000);
      add(0, LW, 0, 0, 3, 5'b01000);
      add(1, LW, 0, 0, 3, 5'b00000); add(1, LW, 0, 0, 0, 5'b00000);
      add(1, LW, 0, 0, 0, 5'b00000);
      add(0, LW, 0, 1, 0, 5'b11000); add(0, LW, 0, 1, 1, 5'b00000);

      msk = '0;
      msk.pc_write = 1; msk.pc_write_cond = 1; msk.pc_en = 1; msk.ir_write = 1;
      msk.mem_read = 1; msk.mem_write = 1; msk.reg_write = 1; msk.illegal_op = 1;

      drive(1'b1, LW, 1'b0, 1'b1);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].mr);
         sb.push_back(tbl[i]);
         #1;
         cur = sb.pop_front();
         act = sample();
         exp = model(cur.st, cur.rst, cur.mr, cur.zero, cur.op);
         check($sformatf("row%0d_state", i), 32'(u_if.state), 32'(cur.st));
         check($sformatf("row%0d_keys", i),
               32'({u_if.pc_en, u_if.mem_read, u_if.mem_write, u_if.reg_write, u_if.illegal_op}),
               32'(cur.keys));
         if (cur.rst)
            check($sformatf("row%0d_enables", i), 32'(act & msk), 32'(exp & msk));
         else
            check($sformatf("row%0d_ctrl", i), 32'(act), 32'(exp));
      end

      measure("lw", LW, 5);
      measure("sw", SW, 4);
      measure("r", RT, 4);
      measure("addi", ADDI, 4);
      measure("beq", BEQ, 3);
      measure("j", JMP, 3);
      measure("ill", ILL, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle variant of the MIPS datapath. Shares one ALU and one unified instruction/data memory across 3–5 cycles per instruction.
- Decodes the opcode latched in the instruction register and drives every mux select and write enable: PC, IR, register file, memory.
- Stretches memory states with a ready handshake so slow memory can be used.
- Sits beside ALUControl, which consumes its alu_op.

Parameters:
- OP_W, 6, opcode field width.
- STATE_W, 4, encoded state width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  Instruction[31:26] from the IR.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory done this cycle (read data valid / write accepted).
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_en  out  1  pc_write | (pc_write_cond & zero).
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR.
- pc_source  out  2  next PC: 0=ALU, 1=ALUOut, 2=jump target.
- alu_op  out  2  to ALUControl: 0=add, 1=sub, 2=funct.
- alu_src_a  out  1  ALU A input: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B input: 0=B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  write register: 0=rt, 1=rd.
- illegal_op  out  1  pulses 1 cycle in DECODE when opcode is unsupported.
- state  out  4  current state, for debug.

Behaviour:
- Supported opcodes:
  - R=000000
  - LW=100011
  - SW=101011
  - BEQ=000100
  - J=000010
  - ADDI=001000
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- All outputs are decoded combinationally from the state register (plus zero for pc_en). Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready; otherwise hold in FETCH.
  - Next: DECODE when mem_ready, else FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (precomputes the branch target).
  - Next: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX. Any other opcode→FETCH with illegal_op=1 (instruction skipped; PC already advanced).
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=0.
  - Next: LW→MEMRD, SW→MEMWR.
- MEMRD:
  - Outputs: mem_read=1, i_or_d=1.
  - Next: MEMWB when mem_ready, else hold.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next: FETCH.
- MEMWR:
  - Outputs: mem_write=1, i_or_d=1.
  - Next: FETCH when mem_ready, else hold. mem_write stays asserted while holding.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=2.
  - Next: RWB.
- RWB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Next: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1.
  - Next: FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=2.
  - Next: FETCH.
- ADDIEX:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=0.
  - Next: ADDIWB.
- ADDIWB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Next: FETCH.
- Latency with mem_ready tied 1:
  - LW 5 cycles.
  - SW, R, ADDI 4 cycles.
  - BEQ, J 3 cycles.
  - Each wait cycle in FETCH/MEMRD/MEMWR adds 1.
- Reset:
  - rst=1 at a rising edge → state=FETCH next cycle, overriding any transition, including mid-instruction or mid-wait.
  - While rst=1, all write enables and strobes (pc_write, pc_write_cond, pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op) are forced to 0. Selects are don't-care.
  - After release, the first cycle is FETCH.
- Unused state encodings 12–15 → FETCH next cycle, all enables 0.
- Opcode is sampled only in DECODE/MEMADR. The IR is stable there because ir_write=0.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - state enum typedef;
  - alu_op, alu_src_b and pc_source encodings.
- Sub-module mips_ctrl_decode: purely combinational state→control-word decode. The top keeps the state register and next-state logic.

Test Plan:
- Reset: hold rst 3 cycles in the middle of LW's MEMRD → state=0, all enables 0 during reset; first post-reset cycle FETCH with mem_read=1.
- LW, mem_ready=1: states 0,1,2,3,4,0 → reg_write=1 and mem_to_reg=1 only in the state-4 cycle; total 5 cycles.
- SW with mem_ready low for 2 cycles in MEMWR → 3 consecutive cycles with mem_write=1, i_or_d=1, then FETCH.
- BEQ with zero=1 → pc_en=1, pc_source=1 in BRANCH. Repeat with zero=0 → pc_en=0.
- J → JUMP state with pc_write=1, pc_source=2; back to FETCH after 3 cycles total.
- Opcode 111111 → illegal_op=1 for exactly one DECODE cycle, next state FETCH, no reg_write or mem_write.
